// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM sprite DMA controller: the CPU side, the shared-memory side and the PPU OAM write port.
// The master modport is the controller's view. The slave modport is the view of the surrounding system.
interface oam_dma_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned REG_WIDTH  = 8
);
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [REG_WIDTH-1:0]  cpu_dout;
    logic                  cpu_we;
    logic                  cpu_rdy;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  mem_din;
    logic [REG_WIDTH-1:0]  mem_dout;
    logic [7:0]            oam_base;
    logic [7:0]            oam_addr;
    logic [REG_WIDTH-1:0]  oam_data;
    logic                  oam_we;
    logic                  dma_busy;
    logic                  dma_done;

    modport master (
        input  cpu_addr, cpu_dout, cpu_we, mem_dout, oam_base,
        output cpu_rdy, mem_addr, mem_we, mem_din, oam_addr, oam_data, oam_we, dma_busy, dma_done
    );

    modport slave (
        output cpu_addr, cpu_dout, cpu_we, mem_dout, oam_base,
        input  cpu_rdy, mem_addr, mem_we, mem_din, oam_addr, oam_data, oam_we, dma_busy, dma_done
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA: a CPU write to $4014 copies one CPU page into PPU OAM while the CPU is held off the bus.
// At all other times CPU bus traffic passes straight through to memory.
module oam_dma_ctrl #(
    parameter int unsigned          ADDR_WIDTH   = 16,
    parameter int unsigned          REG_WIDTH    = 8,
    parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = 16'h4014,
    parameter int unsigned          XFER_LEN     = 256
) (
    input  logic         clk,
    input  logic         reset_n,
    oam_dma_if.master    bus
);
    localparam int unsigned IDX_WIDTH = 8;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(XFER_LEN - 1);

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

    state_t                 state, state_nxt;
    logic [IDX_WIDTH-1:0]   idx, idx_nxt;
    logic [REG_WIDTH-1:0]   page, page_nxt;
    logic [7:0]             base, base_nxt;
    logic                   parity;
    logic                   dma_done, done_nxt;
    logic [ADDR_WIDTH-1:0]  dma_addr;

    assign dma_addr     = ADDR_WIDTH'({page, idx});
    assign bus.dma_done = dma_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            idx      <= '0;
            page     <= '0;
            base     <= '0;
            parity   <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            page     <= page_nxt;
            base     <= base_nxt;
            parity   <= ~parity;
            dma_done <= done_nxt;
        end
    end

    // Next state and outputs. Only IDLE passes CPU inputs through to the outputs.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        page_nxt     = page;
        base_nxt     = base;
        done_nxt     = 1'b0;
        bus.cpu_rdy  = 1'b0;
        bus.dma_busy = 1'b1;
        bus.mem_addr = dma_addr;
        bus.mem_we   = 1'b0;
        bus.mem_din  = '0;
        bus.oam_we   = 1'b0;
        bus.oam_addr = '0;
        bus.oam_data = '0;

        case (state)
            IDLE: begin
                bus.cpu_rdy  = 1'b1;
                bus.dma_busy = 1'b0;
                bus.mem_addr = bus.cpu_addr;
                bus.mem_we   = bus.cpu_we;
                bus.mem_din  = bus.cpu_dout;
                if (bus.cpu_we && bus.cpu_addr == DMA_REG_ADDR) begin
                    page_nxt  = bus.cpu_dout;
                    base_nxt  = bus.oam_base;
                    idx_nxt   = '0;
                    state_nxt = HALT;
                end
            end
            // An odd-parity halt cycle needs one extra cycle to get onto a read slot.
            HALT:  state_nxt = parity ? ALIGN : READ;
            ALIGN: state_nxt = READ;
            READ:  state_nxt = WRITE;
            WRITE: begin
                bus.oam_we   = 1'b1;
                bus.oam_data = bus.mem_dout;
                bus.oam_addr = base + idx;
                if (idx == LAST_IDX) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    idx_nxt   = idx + IDX_WIDTH'(1);
                    state_nxt = READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: reset, even- and odd-parity transfers, OAM base wrap, abort, and passthrough.
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    oam_dma_if #(.ADDR_WIDTH(16), .REG_WIDTH(8)) bus ();

    oam_dma_ctrl #(.ADDR_WIDTH(16), .REG_WIDTH(8), .DMA_REG_ADDR(16'h4014), .XFER_LEN(256)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Shared memory with a one-cycle read latency, and a PPU OAM that records writes.
    logic [7:0] mem [65536];
    logic [7:0] oam [256];
    always @(posedge clk) begin
        bus.mem_dout <= mem[bus.mem_addr];
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
        if (bus.oam_we) oam[bus.oam_addr] <= bus.oam_data;
    end

    // Expected value of the parity register: 0 in reset, then it toggles on every clock.
    logic tb_par;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) tb_par <= 1'b0;
        else          tb_par <= ~tb_par;

    // Per-transfer observations, filled in by capture().
    int rdy_low, writes, dones, first_low, last_low, done_cyc, memwe_err;
    bit timed_out;
    logic [7:0]  wr_addr  [256];
    logic [7:0]  wr_data  [256];
    logic [15:0] wr_maddr [256];

    task automatic trigger(input logic [7:0] page, input logic want_par);
        @(negedge clk);
        if (tb_par == want_par) @(negedge clk);
        bus.cpu_addr = 16'h4014; bus.cpu_we = 1'b1; bus.cpu_dout = page;
        @(negedge clk);
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000; bus.cpu_dout = 8'h00;
    endtask

    // Records what the controller does, starting with the cycle after the trigger (cycle 1).
    task automatic capture(input int stop_at, input int change_at);
        int cyc;
        int post;
        bit seen_low;
        rdy_low = 0; writes = 0; dones = 0; first_low = -1; last_low = -1;
        done_cyc = -1; memwe_err = 0; timed_out = 1'b0; seen_low = 1'b0; post = 0;
        for (cyc = 1; cyc < 1200; cyc++) begin
            if (!bus.cpu_rdy) begin
                rdy_low++;
                if (first_low < 0) first_low = cyc;
                last_low = cyc;
                seen_low = 1'b1;
            end
            if (bus.dma_done) begin dones++; done_cyc = cyc; end
            if (bus.dma_busy && bus.mem_we) memwe_err++;
            if (bus.oam_we && writes < 256) begin
                wr_addr[writes] = bus.oam_addr;
                wr_data[writes] = bus.oam_data;
                wr_maddr[writes] = bus.mem_addr;
                writes++;
            end
            if (stop_at > 0 && writes == stop_at) return;
            if (change_at > 0 && writes == change_at) bus.oam_base = 8'h33;
            if (seen_low && bus.cpu_rdy) begin
                post++;
                if (post == 3) return;
            end
            @(negedge clk);
        end
        timed_out = 1'b1;
    endtask

    task automatic fill_page(input logic [7:0] page, input logic [7:0] key);
        for (int i = 0; i < 256; i++) mem[{page, 8'(i)}] = 8'(i) ^ key;
    endtask

    task automatic test_reset;
        bus.cpu_addr = 16'h4014; bus.cpu_we = 1'b1; bus.cpu_dout = 8'h02; bus.oam_base = 8'h00;
        reset_n = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            vectors++;
            if ({bus.cpu_rdy, bus.oam_we, bus.dma_busy, bus.dma_done} !== 4'b1000) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d rdy/we/busy/done got %b exp 1000", c,
                         {bus.cpu_rdy, bus.oam_we, bus.dma_busy, bus.dma_done});
            end
        end
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.dma_busy !== 1'b0 || bus.cpu_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL post_reset_idle cyc=%0d busy=%b rdy=%b exp busy=0 rdy=1", c, bus.dma_busy, bus.cpu_rdy);
            end
        end
    endtask

    task automatic test_even_parity;
        int bad;
        fill_page(8'h02, 8'h5A);
        bus.oam_base = 8'h00;
        trigger(8'h02, 1'b0);
        capture(0, 0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wr_addr[i] !== 8'(i) || wr_data[i] !== (8'(i) ^ 8'h5A) || wr_maddr[i] !== (16'h0200 + 16'(i))) bad++;
        vectors++;
        if (timed_out || rdy_low != 513) begin
            miscompares++; $display("FAIL even_rdy_low got %0d exp 513 (timeout=%0d)", rdy_low, timed_out);
        end
        vectors++;
        if (first_low != 1 || last_low != 513 || done_cyc != 514) begin
            miscompares++;
            $display("FAIL even_timing first=%0d last=%0d done=%0d exp 1 513 514", first_low, last_low, done_cyc);
        end
        vectors++;
        if (writes != 256 || dones != 1) begin
            miscompares++; $display("FAIL even_counts writes=%0d dones=%0d exp 256 1", writes, dones);
        end
        vectors++;
        if (bad != 0 || memwe_err != 0) begin
            miscompares++; $display("FAIL even_sequence bad=%0d memwe=%0d exp 0 0", bad, memwe_err);
        end
    endtask

    task automatic test_odd_parity;
        int bad;
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
        bus.oam_base = 8'h00;
        trigger(8'h02, 1'b1);
        capture(0, 0);
        vectors++;
        if (timed_out || rdy_low != 514 || first_low != 1 || done_cyc != 515) begin
            miscompares++;
            $display("FAIL odd_timing low=%0d first=%0d done=%0d exp 514 1 515", rdy_low, first_low, done_cyc);
        end
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 256; i++) if (oam[i] !== (8'(i) ^ 8'h5A)) bad++;
        vectors++;
        if (bad != 0 || writes != 256 || dones != 1) begin
            miscompares++; $display("FAIL odd_oam bad=%0d writes=%0d dones=%0d exp 0 256 1", bad, writes, dones);
        end
    endtask

    task automatic test_base_wrap;
        int bad;
        fill_page(8'h03, 8'hC3);
        bus.oam_base = 8'hF0;
        trigger(8'h03, 1'b0);
        capture(0, 50);
        vectors++;
        if (wr_addr[0] !== 8'hF0 || wr_addr[15] !== 8'hFF || wr_addr[16] !== 8'h00 || wr_addr[255] !== 8'hEF) begin
            miscompares++;
            $display("FAIL wrap_points got %h %h %h %h exp f0 ff 00 ef", wr_addr[0], wr_addr[15], wr_addr[16], wr_addr[255]);
        end
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wr_addr[i] !== 8'(8'hF0 + 8'(i)) || wr_data[i] !== (8'(i) ^ 8'hC3) || wr_maddr[i] !== (16'h0300 + 16'(i))) bad++;
        vectors++;
        if (timed_out || bad != 0 || writes != 256) begin
            miscompares++; $display("FAIL wrap_sequence bad=%0d writes=%0d exp 0 256", bad, writes);
        end
        bus.oam_base = 8'h00;
    endtask

    task automatic test_abort;
        int stray;
        trigger(8'h02, 1'b0);
        capture(100, 0);
        vectors++;
        if (writes != 100) begin
            miscompares++; $display("FAIL abort_reach writes=%0d exp 100", writes);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({bus.cpu_rdy, bus.oam_we, bus.dma_busy, bus.dma_done} !== 4'b1000) begin
            miscompares++;
            $display("FAIL abort_async rdy/we/busy/done got %b exp 1000", {bus.cpu_rdy, bus.oam_we, bus.dma_busy, bus.dma_done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.dma_done || bus.oam_we || !bus.cpu_rdy) stray++;
        end
        vectors++;
        if (stray != 0) begin
            miscompares++; $display("FAIL abort_quiet stray=%0d exp 0", stray);
        end
        trigger(8'h02, 1'b0);
        capture(0, 0);
        vectors++;
        if (timed_out || writes != 256 || wr_maddr[0] !== 16'h0200 || wr_addr[0] !== 8'h00 || wr_data[0] !== 8'h5A) begin
            miscompares++;
            $display("FAIL abort_restart writes=%0d maddr0=%h oaddr0=%h data0=%h exp 256 0200 00 5a",
                     writes, wr_maddr[0], wr_addr[0], wr_data[0]);
        end
    endtask

    task automatic test_passthrough;
        logic [15:0] addrs [3];
        logic [7:0]  dins  [3];
        logic        wes   [3];
        addrs[0] = 16'h4015; dins[0] = 8'h07; wes[0] = 1'b1;
        addrs[1] = 16'h4014; dins[1] = 8'h00; wes[1] = 1'b0;
        addrs[2] = 16'h4013; dins[2] = 8'h99; wes[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.cpu_addr = addrs[k]; bus.cpu_dout = dins[k]; bus.cpu_we = wes[k];
            #1;
            vectors++;
            if (bus.mem_addr !== addrs[k] || bus.mem_we !== wes[k] || bus.mem_din !== dins[k] || bus.cpu_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL passthrough k=%0d addr=%h we=%b din=%h rdy=%b exp %h %b %h 1",
                         k, bus.mem_addr, bus.mem_we, bus.mem_din, bus.cpu_rdy, addrs[k], wes[k], dins[k]);
            end
        end
        @(negedge clk);
        bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0000;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.dma_busy !== 1'b0 || bus.oam_we !== 1'b0 || bus.cpu_rdy !== 1'b1) begin
                miscompares++;
                $display("FAIL passthrough_idle c=%0d busy=%b oam_we=%b rdy=%b exp 0 0 1", c, bus.dma_busy, bus.oam_we, bus.cpu_rdy);
            end
        end
    endtask

    initial begin
        bus.cpu_addr = 16'h0000; bus.cpu_dout = 8'h00; bus.cpu_we = 1'b0; bus.oam_base = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_base_wrap();
        test_abort();
        test_passthrough();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
NES sprite DMA controller. It sits on the bus between cpu_top and the shared mem block. A CPU write to $4014 starts a 256-byte copy from CPU page $XX00–$XXFF into PPU OAM. During the copy it holds the CPU off the bus with rdy and owns the memory address and write-enable lines; at all other times it passes CPU traffic straight through.

Parameters:
ADDR_WIDTH, 16, CPU/memory address width
REG_WIDTH, 8, data width
DMA_REG_ADDR, 16'h4014, trigger register address
XFER_LEN, 256, bytes per transfer (power of two, max 256)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
cpu_addr  input  ADDR_WIDTH  CPU address bus
cpu_dout  input  REG_WIDTH  CPU write data
cpu_we  input  1  CPU write strobe (inverse of R_W_n)
cpu_rdy  output  1  to CPU rdy; low halts the CPU
mem_addr  output  ADDR_WIDTH  address to mem
mem_we  output  1  write enable to mem
mem_din  output  REG_WIDTH  write data to mem
mem_dout  input  REG_WIDTH  read data from mem; valid 1 cycle after mem_addr
oam_base  input  8  PPU OAMADDR value, sampled at trigger
oam_addr  output  8  OAM write address
oam_data  output  REG_WIDTH  OAM write data
oam_we  output  1  OAM write strobe
dma_busy  output  1  high in any non-IDLE state
dma_done  output  1  one-cycle pulse on transfer completion

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, page=0, base=0, parity=0, dma_done=0. Outputs: cpu_rdy=1, oam_we=0, oam_addr=0, oam_data=0, dma_busy=0.
- parity: 1-bit register, toggles every clk, reset 0.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - Passthrough: mem_addr=cpu_addr, mem_we=cpu_we, mem_din=cpu_dout.
  - If cpu_we && cpu_addr==DMA_REG_ADDR: latch page=cpu_dout and base=oam_base, clear idx, go to HALT.
  - The trigger write itself also reaches mem.
  - Reads of $4014 and writes to other addresses do nothing.
- HALT: exactly one cycle. If parity==1, go to ALIGN; else go to READ.
- ALIGN: exactly one cycle, then go to READ.
- READ: mem_addr={page, idx}, then go to WRITE.
- WRITE:
  - oam_we=1, oam_data=mem_dout, oam_addr=(base+idx) mod 256 (8-bit wrap).
  - If idx==XFER_LEN-1, go to IDLE and assert dma_done for the first IDLE cycle. Otherwise idx++ and go to READ.
- All non-IDLE states: cpu_rdy=0, dma_busy=1, mem_we=0, mem_din=0, mem_addr={page, idx}. The DMA never writes memory.
- Non-WRITE states: oam_we=0, oam_addr=0, oam_data=0.
- Outputs decode from registered state only (no CPU-input-to-cpu_rdy combinational path), except the IDLE passthrough.
- Timing, trigger at cycle T:
  - cpu_rdy low from T+1.
  - Even parity: first READ at T+2, last WRITE at T+513, cpu_rdy=1 and dma_done=1 at T+514 (513 halted cycles).
  - Odd parity: everything shifts one cycle later (514 halted cycles).
- The CPU is guaranteed halted while cpu_rdy=0, so CPU inputs are ignored outside IDLE. A $4014 write seen outside IDLE is ignored.
- oam_base changes after the trigger do not affect an in-flight transfer.
- Reset mid-transfer: immediate abort. No further oam_we, cpu_rdy=1, no dma_done pulse. Partially written OAM is left as is.

Test Plan:
1. Hold reset_n=0 and toggle clk, with cpu_we=1 @ $4014 -> cpu_rdy=1, oam_we=0, dma_busy=0, dma_done=0 throughout. No DMA starts after release until a new trigger.
2. Fill mem $0200–$02FF with i^8'h5A, oam_base=0, write 8'h02 to $4014 with parity=0 -> 256 oam_we pulses, oam_addr=i, oam_data=i^8'h5A, mem_addr $0200..$02FF in order, mem_we=0, cpu_rdy low exactly 513 cycles, one dma_done pulse.
3. Same as 2 but trigger with parity=1 -> one ALIGN cycle, cpu_rdy low exactly 514 cycles, identical OAM contents.
4. oam_base=8'hF0, page $03 -> byte 0 to oam_addr F0, byte 15 to FF, byte 16 to 00, byte 255 to EF. Changing oam_base mid-transfer has no effect.
5. Pulse reset_n low after 100 OAM writes -> cpu_rdy=1 and oam_we=0 asynchronously, no dma_done. A new trigger restarts at idx 0 with mem_addr={page,8'h00}.
6. CPU writes 8'h07 to $4015, reads $4014, writes $4013 -> no state change. mem_addr/mem_we/mem_din mirror the CPU each cycle, cpu_rdy stays 1.
